// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Receives a program image as a UART byte stream and writes it
//               into instruction memory. After a start pulse the loader takes
//               a 4-byte big-endian word count N, then N big-endian 32-bit
//               words, emitting one write pulse per completed word.
//               Optional feature macro: LOADER_CHECKSUM_EN. When defined, a
//               running XOR of all header and data bytes is compared with one
//               trailing checksum byte before the session is declared done.
// Ports       : clk        rising-edge clock
//               rstn       asynchronous active-low reset
//               start      one-cycle pulse, begins a load session
//               rx_data    received byte
//               rx_valid   one-cycle strobe qualifying rx_data / rx_ferr
//               rx_ferr    framing error for the current byte
//               we         one-cycle write pulse per assembled word
//               waddr      word address of the write (held between writes)
//               wdata      word of the write (held between writes)
//               busy       session in progress
//               load_done  session completed successfully (level)
//               load_err   session aborted (level)
// Revision    : 1.0  initial release
// ============================================================================
module program_loader #(
   parameter int INST_SIZE = 10
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 start,
   input  logic [7:0]           rx_data,
   input  logic                 rx_valid,
   input  logic                 rx_ferr,
   output logic                 we,
   output logic [INST_SIZE-1:0] waddr,
   output logic [31:0]          wdata,
   output logic                 busy,
   output logic                 load_done,
   output logic                 load_err
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LEN  = 3'd1,
      S_DATA = 3'd2,
`ifdef LOADER_CHECKSUM_EN
      S_CHK  = 3'd3,
`endif
      S_DONE = 3'd4,
      S_ERR  = 3'd5
   } state_t;

   // Memory capacity in words; a header larger than this cannot be stored.
   localparam logic [32:0] c_capacity = 33'd1 << INST_SIZE;

   // State reached once the payload is complete (or the header is zero).
`ifdef LOADER_CHECKSUM_EN
   localparam state_t c_tail_state = S_CHK;
`else
   localparam state_t c_tail_state = S_DONE;
`endif

   state_t               state_q, state_d;
   logic [1:0]           byte_cnt_q, byte_cnt_d;
   logic [23:0]          shift_q, shift_d;     // previous up to 3 bytes
   logic [INST_SIZE-1:0] widx_q, widx_d;
   logic [INST_SIZE-1:0] last_q, last_d;       // index of final word, N-1
   logic                 we_q, we_d;
   logic [INST_SIZE-1:0] waddr_q, waddr_d;
   logic [31:0]          wdata_q, wdata_d;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]           csum_q, csum_d;
`endif

   logic        w_byte;
   logic        w_ferr;
   logic [31:0] w_word;

   assign w_byte = rx_valid & ~rx_ferr;
   assign w_ferr = rx_valid &  rx_ferr;
   // Word formed if the current byte is the fourth of a group.
   assign w_word = {shift_q, rx_data};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= S_IDLE;
         byte_cnt_q <= 2'd0;
         shift_q    <= 24'd0;
         widx_q     <= '0;
         last_q     <= '0;
         we_q       <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
         csum_q     <= 8'd0;
`endif
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         shift_q    <= shift_d;
         widx_q     <= widx_d;
         last_q     <= last_d;
         we_q       <= we_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      shift_d    = shift_q;
      widx_d     = widx_q;
      last_d     = last_q;
      we_d       = 1'b0;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
`ifdef LOADER_CHECKSUM_EN
      csum_d     = csum_q;
`endif

      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            // Any byte arriving alongside start is dropped here by design.
            if (start) begin
               state_d    = S_LEN;
               byte_cnt_d = 2'd0;
               shift_d    = 24'd0;
               widx_d     = '0;
`ifdef LOADER_CHECKSUM_EN
               csum_d     = 8'd0;
`endif
            end
         end

         S_LEN: begin
            if (w_ferr) begin
               state_d = S_ERR;
            end else if (w_byte) begin
               shift_d    = w_word[23:0];
               byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
               csum_d     = csum_q ^ rx_data;
`endif
               if (byte_cnt_q == 2'd3) begin
                  if ({1'b0, w_word} > c_capacity) begin
                     state_d = S_ERR;
                  end else if (w_word == 32'd0) begin
                     state_d = c_tail_state;
                  end else begin
                     state_d = S_DATA;
                     // N <= capacity, so N-1 always fits the index width.
                     last_d  = INST_SIZE'(w_word - 32'd1);
                  end
               end
            end
         end

         S_DATA: begin
            if (w_ferr) begin
               state_d = S_ERR;
            end else if (w_byte) begin
               shift_d    = w_word[23:0];
               byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
               csum_d     = csum_q ^ rx_data;
`endif
               if (byte_cnt_q == 2'd3) begin
                  we_d    = 1'b1;
                  waddr_d = widx_q;
                  wdata_d = w_word;
                  widx_d  = widx_q + 1'b1;
                  // Leaving DATA on the same edge as the final write makes
                  // load_done rise together with that last we pulse.
                  if (widx_q == last_q) begin
                     state_d = c_tail_state;
                  end
               end
            end
         end

`ifdef LOADER_CHECKSUM_EN
         S_CHK: begin
            if (w_ferr) begin
               state_d = S_ERR;
            end else if (w_byte) begin
               state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
            end
         end
`endif

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign we        = we_q;
   assign waddr     = waddr_q;
   assign wdata     = wdata_q;
   assign load_done = (state_q == S_DONE);
   assign load_err  = (state_q == S_ERR);
`ifdef LOADER_CHECKSUM_EN
   assign busy      = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHK);
`else
   assign busy      = (state_q == S_LEN) || (state_q == S_DATA);
`endif

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_loader
// Description : Self-checking bench for program_loader. A byte-level reference
//               model predicts write pulses and session status after every
//               clock; directed sessions plus randomized loads are applied.
//               Follows LOADER_CHECKSUM_EN when the macro is defined.
// Revision    : 1.0  initial release
// ============================================================================
module tb_program_loader;

   localparam int IS  = 10;
   localparam int CAP = 1 << IS;
`ifdef LOADER_CHECKSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif

   typedef logic [7:0] bq_t[$];

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          start = 1'b0;
   logic [7:0]    rx_data = 8'd0;
   logic          rx_valid = 1'b0;
   logic          rx_ferr = 1'b0;
   logic          we;
   logic [IS-1:0] waddr;
   logic [31:0]   wdata;
   logic          busy, load_done, load_err;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: phase 0 header, 1 payload, 2 checksum, 3 done, 4 error.
   int          m_phase;
   int          m_cnt;
   logic [31:0] m_hdr;
   logic [31:0] m_word;
   logic [7:0]  m_x;

   always #5 clk = ~clk;

   program_loader #(.INST_SIZE(IS)) dut (
      .clk(clk), .rstn(rstn), .start(start), .rx_data(rx_data),
      .rx_valid(rx_valid), .rx_ferr(rx_ferr), .we(we), .waddr(waddr),
      .wdata(wdata), .busy(busy), .load_done(load_done), .load_err(load_err)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_status(input string tag);
      check_val({tag, " busy"}, 32'(busy),      32'(m_phase < 3));
      check_val({tag, " done"}, 32'(load_done), 32'(m_phase == 3));
      check_val({tag, " err"},  32'(load_err),  32'(m_phase == 4));
   endtask

   // Feed one accepted byte (or framing error) into the model.
   task automatic model_byte(input logic [7:0] b, input bit ferr,
                             output bit ewe, output int eaddr, output logic [31:0] edata);
      ewe = 1'b0; eaddr = 0; edata = 32'd0;
      if (m_phase >= 3) return;
      if (ferr) begin
         m_phase = 4;
         return;
      end
      m_x = m_x ^ b;
      if (m_phase == 0) begin
         m_hdr = {m_hdr[23:0], b};
         m_cnt++;
         if (m_cnt == 4) begin
            m_cnt = 0;
            if (m_hdr > 32'(CAP))  m_phase = 4;
            else if (m_hdr == 0)   m_phase = CSUM ? 2 : 3;
            else                   m_phase = 1;
         end
      end else if (m_phase == 1) begin
         m_word = {m_word[23:0], b};
         m_cnt++;
         if (m_cnt % 4 == 0) begin
            ewe   = 1'b1;
            eaddr = m_cnt / 4 - 1;
            edata = m_word;
            if (32'(m_cnt / 4) == m_hdr) m_phase = CSUM ? 2 : 3;
         end
      end else begin
         // Checksum byte: m_x already includes b, so a match leaves zero.
         m_phase = (m_x == 8'd0) ? 3 : 4;
      end
   endtask

   // All tasks begin and end at a falling edge: drive, clock, then sample.
   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         if (m_phase < 3) begin
            start = ($urandom_range(0, 3) == 0);    // must be ignored
         end else begin
            rx_valid = $urandom_range(0, 1);        // stray bytes, ignored
            rx_ferr  = $urandom_range(0, 1);
            rx_data  = 8'($urandom);
         end
         @(posedge clk);
         @(negedge clk);
         start = 1'b0; rx_valid = 1'b0; rx_ferr = 1'b0;
         check_val("gap we", 32'(we), 32'd0);
         check_status("gap");
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit ferr);
      bit          ewe;
      int          eaddr;
      logic [31:0] edata;
      rx_valid = 1'b1; rx_data = b; rx_ferr = ferr;
      @(posedge clk);
      @(negedge clk);
      rx_valid = 1'b0; rx_ferr = 1'b0;
      model_byte(b, ferr, ewe, eaddr, edata);
      check_val("byte we", 32'(we), 32'(ewe));
      if (ewe) begin
         check_val("waddr", 32'(waddr), 32'(eaddr));
         check_val("wdata", wdata, edata);
      end
      check_status("byte");
   endtask

   task automatic start_session();
      start    = 1'b1;
      rx_valid = $urandom_range(0, 1);              // discarded with start
      rx_ferr  = $urandom_range(0, 1);
      rx_data  = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; rx_valid = 1'b0; rx_ferr = 1'b0;
      m_phase = 0; m_cnt = 0; m_hdr = 32'd0; m_word = 32'd0; m_x = 8'd0;
      check_val("start we", 32'(we), 32'd0);
      check_status("start");
   endtask

   task automatic run_session(input bq_t q, input int ferr_at, input int maxgap);
      start_session();
      for (int i = 0; i < q.size(); i++) begin
         if (m_phase >= 3) break;
         idle_cycles($urandom_range(0, maxgap));
         send_byte(q[i], i == ferr_at);
      end
      idle_cycles(2);
   endtask

   function automatic bq_t with_csum(input bq_t q);
      bq_t        r = q;
      logic [7:0] x = 8'd0;
      foreach (q[i]) x = x ^ q[i];
      if (CSUM) r.push_back(x);
      return r;
   endfunction

   function automatic bq_t build_rand(input int n);
      bq_t q;
      logic [31:0] h = 32'(n);
      for (int i = 3; i >= 0; i--) q.push_back(h[8*i +: 8]);
      for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
      return with_csum(q);
   endfunction

   initial begin
      bq_t q;
      m_phase = 0;
      // Reset state
      #12;
      check_val("rst we",    32'(we),        32'd0);
      check_val("rst busy",  32'(busy),      32'd0);
      check_val("rst done",  32'(load_done), 32'd0);
      check_val("rst err",   32'(load_err),  32'd0);
      check_val("rst waddr", 32'(waddr),     32'd0);
      check_val("rst wdata", wdata,          32'd0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);

      // Two-word directed load
      q = {8'h00, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
           8'h9A, 8'hBC, 8'hDE, 8'hF0};
      run_session(with_csum(q), -1, 1);
      check_val("two-word done", 32'(load_done), 32'd1);

      // Zero-length header
      q = {8'h00, 8'h00, 8'h00, 8'h00};
      run_session(with_csum(q), -1, 1);
      check_val("zero-len done", 32'(load_done), 32'd1);

      // Header one past capacity
      q = {8'h00, 8'h00, 8'h04, 8'h01};
      run_session(q, -1, 1);
      check_val("oversize err", 32'(load_err), 32'd1);

      // Full-capacity load
      run_session(build_rand(CAP), -1, 1);
      check_val("full done", 32'(load_done), 32'd1);
      check_val("full last waddr", 32'(waddr), 32'(CAP - 1));

      // Framing error on the 6th byte of a 2-word load, then recovery
      run_session(build_rand(2), 5, 1);
      check_val("ferr err", 32'(load_err), 32'd1);
      run_session(build_rand(2), -1, 1);
      check_val("recover done", 32'(load_done), 32'd1);
      check_val("recover err",  32'(load_err),  32'd0);

`ifdef LOADER_CHECKSUM_EN
      q = {8'h00, 8'h00, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01};
      run_session(q, -1, 1);
      check_val("csum ok done", 32'(load_done), 32'd1);
      q = {8'h00, 8'h00, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
      run_session(q, -1, 1);
      check_val("csum bad err", 32'(load_err), 32'd1);
      check_val("csum bad wdata kept", wdata, 32'hAABBCCDD);
`endif

      // Randomized sessions, some with framing errors or bad checksums
      for (int s = 0; s < 25; s++) begin
         int n  = $urandom_range(1, 6);
         int fa = -1;
         q = build_rand(n);
         if ($urandom_range(0, 2) == 0) fa = $urandom_range(0, q.size() - 1);
         if (CSUM && $urandom_range(0, 3) == 0) q[q.size() - 1] = q[q.size() - 1] ^ 8'h5A;
         run_session(q, fa, 2);
      end

      // Asynchronous reset in the middle of DATA, right after a write
      start_session();
      q = {8'h00, 8'h00, 8'h00, 8'h02, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
      foreach (q[i]) send_byte(q[i], 1'b0);
      #2 rstn = 1'b0;
      #1;
      check_val("mid rst we",    32'(we),        32'd0);
      check_val("mid rst waddr", 32'(waddr),     32'd0);
      check_val("mid rst wdata", wdata,          32'd0);
      check_val("mid rst busy",  32'(busy),      32'd0);
      check_val("mid rst done",  32'(load_done), 32'd0);
      check_val("mid rst err",   32'(load_err),  32'd0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      run_session(build_rand(3), -1, 1);
      check_val("post rst done", 32'(load_done), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter INST_SIZE, default 10: instruction-memory word-address width; capacity 2^INST_SIZE words.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rstn  in  1  reset, asynchronous assert, active-low.
REQ-004 start  in  1  one-cycle pulse that begins a load session (issued after the 0xAA sync byte).
REQ-005 rx_data  in  8  received UART byte.
REQ-006 rx_valid  in  1  one-cycle strobe, rx_data valid.
REQ-007 rx_ferr  in  1  framing error, qualified by rx_valid.
REQ-008 we  out  1  instruction-memory write enable, one-cycle pulse per word.
REQ-009 waddr  out  INST_SIZE  word address of the current write.
REQ-010 wdata  out  32  instruction word of the current write.
REQ-011 busy  out  1  high in LEN, DATA and CHK.
REQ-012 load_done  out  1  level, session completed successfully.
REQ-013 load_err  out  1  level, session aborted.

Function
REQ-014 States: IDLE, LEN, DATA, CHK (macro only), DONE, ERR.
REQ-015 IDLE/DONE/ERR + start -> LEN; clear load_done, load_err, byte counter, word index, checksum.
REQ-016 start in LEN/DATA/CHK is ignored.
REQ-017 A byte with rx_valid in the same cycle as an accepted start is discarded; the first header byte is the next rx_valid.
REQ-018 LEN: 4 bytes, big-endian, give word count N (32 bit).
REQ-019 After the 4th header byte: N > 2^INST_SIZE -> ERR; N == 0 -> DONE (CHK if macro); otherwise -> DATA.
REQ-020 DATA: bytes assemble big-endian into 32-bit words (first byte = wdata[31:24]).
REQ-021 The 4th byte of word k accepted at cycle t -> we=1 at t+1, waddr=k, wdata=word; we low otherwise.
REQ-022 waddr and wdata hold their last values when we is low; word index does not wrap because N is bounded (REQ-019).
REQ-023 After the write of word N-1 -> DONE (CHK if macro); load_done rises the same cycle as that final we.
REQ-024 rx_valid with rx_ferr in LEN/DATA/CHK -> ERR next cycle; the byte is not used; no further we.
REQ-025 Bytes arriving in IDLE/DONE/ERR are ignored.
REQ-026 DONE and ERR persist until start or reset.
REQ-027 load_done and load_err are never high together.

Reset
REQ-028 rstn low: state=IDLE; we, busy, load_done, load_err = 0; waddr, wdata, counters, checksum = 0; takes effect immediately, independent of clk.
REQ-029 Reset mid-session abandons the session; words already written are not rolled back.

Configuration
REQ-030 Macro LOADER_CHECKSUM_EN defined: a running XOR covers all header and data bytes; after the last word (or a zero-length header) the FSM enters CHK and waits for one byte; byte == XOR -> DONE, else -> ERR; load_done rises the cycle after the checksum byte is accepted.
REQ-031 Macro LOADER_CHECKSUM_EN undefined: there is no CHK state, no checksum logic and no trailing byte (REQ-023 applies).

Verification
REQ-032 start; bytes 00 00 00 02, 12 34 56 78, 9A BC DE F0 -> we at addr 0 = 0x12345678, then addr 1 = 0x9ABCDEF0; load_done=1 with the second we; busy=0 after.
REQ-033 start; header 00 00 00 00 -> no we; DONE (CHK in macro build, checksum byte 0x00 -> load_done=1).
REQ-034 INST_SIZE=10; header 00 00 04 01 -> load_err=1, no we; header 00 00 04 00 followed by 1024 words -> last we at waddr=0x3FF, load_done=1.
REQ-035 rx_ferr=1 on byte 6 of a 2-word load -> load_err=1, no we; a following start plus a valid load -> load_done=1, load_err=0.
REQ-036 LOADER_CHECKSUM_EN build: 1-word load 00 00 00 01 AA BB CC DD; checksum 0x01 -> load_done; checksum 0x00 -> load_err (word still written at addr 0).
REQ-037 rstn pulsed low during DATA -> all outputs 0 immediately; start rx_valid in the same cycle -> that byte is discarded.
